lfsr_rand_pos: RTL and testbench
================================

LFSR_RAND_POS -- requirements
Module: lfsr_rand_pos

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  WIDTH, 16, LFSR width; legal values 8, 16, 24, 32.
  COORD_W, 4, x/y coordinate width; 2*COORD_W <= WIDTH.
  X_MAX, 15, largest legal x.
  Y_MAX, 15, largest legal y.
  SEED, 16'hACE1 (zero-extended or truncated to WIDTH), reset/fallback seed; nonzero.
  MAX_TRIES, 8, rejection attempts per coordinate before clamping.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk        in   1        sole clock, rising edge.
  reset      in   1        asynchronous, active-low reset.
  req        in   1        request a new (x,y) pair.
  seed_load  in   1        load seed_in into the LFSR.
  seed_in    in   WIDTH    seed value.
  busy       out  1        high in GEN_X, GEN_Y or DONE.
  out_valid  out  1        x/y valid.
  out_ready  in   1        consumer accepts x/y.
  x          out  COORD_W  x coordinate.
  y          out  COORD_W  y coordinate.
  lfsr_state out  WIDTH    current LFSR state (debug/verification).

Function
REQ-003 The LFSR SHALL be a maximal-length Galois LFSR that steps once on every clock edge outside reset, regardless of FSM state.
REQ-004 The LFSR SHALL never hold zero; a seed_load with seed_in==0 SHALL load SEED instead.
REQ-005 seed_load SHALL take priority over stepping: lfsr_state==seed_in (or SEED) after that edge.
REQ-006 The FSM SHALL have states IDLE, GEN_X, GEN_Y and DONE.
REQ-007 IDLE SHALL go to GEN_X on an edge with req==1; otherwise it SHALL stay in IDLE.
REQ-008 In GEN_X, the candidate SHALL be lfsr_state[COORD_W-1:0].
REQ-009 In GEN_X, if candidate <= X_MAX, x SHALL capture it and the FSM SHALL go to GEN_Y.
REQ-010 In GEN_X, if candidate > X_MAX, the try counter SHALL increment; on the MAX_TRIES-th rejection, x SHALL be set to X_MAX and the FSM SHALL go to GEN_Y.
REQ-011 GEN_Y SHALL behave as GEN_X, using lfsr_state[WIDTH-1 -: COORD_W], Y_MAX and y, and SHALL go to DONE; the try counter SHALL clear on entry to each GEN state.
REQ-012 out_valid SHALL be high exactly while in DONE, so the minimum latency is out_valid high 2 edges after the edge sampling req.
REQ-013 Latency SHALL be at most 2*MAX_TRIES edges after the edge sampling req.
REQ-014 In DONE, x, y and out_valid SHALL hold stable until an edge with out_ready==1, which SHALL return the FSM to IDLE.
REQ-015 req SHALL be ignored outside IDLE, with no queuing.
REQ-016 seed_load in any state SHALL force the FSM to IDLE, clear out_valid and busy at that edge, and leave x and y unchanged.
REQ-017 With X_MAX >= 2^COORD_W-1, every candidate SHALL be accepted first try; the same SHALL hold for Y_MAX.

Reset
REQ-018 While reset==0, lfsr_state SHALL equal SEED, the FSM SHALL be in IDLE, and x, y, out_valid, busy and the try counter SHALL be 0.
REQ-019 Assertion of reset SHALL take effect immediately, mid-operation included, with no clock required.
REQ-020 The first LFSR step SHALL occur on the first rising edge after reset deasserts.

Structure
REQ-021 Package lfsr_pkg SHALL hold the tap-mask constants for WIDTH 8/16/24/32 and the FSM state encoding.
REQ-022 The LFSR register, step, load and zero-guard logic SHALL live in sub-module lfsr_core (ports clk, reset, load, load_val, state).
REQ-023 lfsr_rand_pos SHALL contain the FSM, the try counter and the output registers.

Verification
REQ-024 The bench SHALL cover these scenarios:
  Reset: release reset with WIDTH=16 -> lfsr_state==16'hACE1 before the first edge; afterwards it matches a reference model each cycle; out_valid==0.
  Period: WIDTH=16, free-run -> lfsr_state returns to 16'hACE1 after exactly 65535 edges and is never 0.
  Latency: X_MAX=Y_MAX=15, pulse req -> out_valid==1 exactly 2 edges later; x==model[3:0] and y==model[15:12] at the sampling edges.
  Clamp: X_MAX=0, Y_MAX=2, MAX_TRIES=4, 50 requests -> x==0 always, y<=2 always, latency <= 8 edges.
  Backpressure: out_ready=0 for 10 cycles with req pulses -> x, y and out_valid stable, no new generation; out_ready=1 -> IDLE the next edge.
  Seed and reset abort: seed_load=1 with seed_in=0 mid-GEN_X -> lfsr_state==16'hACE1, busy==0, out_valid==0 next edge; reset=0 asserted mid-GEN_Y -> all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants for the random-position generator: Galois tap masks
// for the supported LFSR widths and the generator FSM encoding.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN_X = 2'd1,
        ST_GEN_Y = 2'd2,
        ST_DONE  = 2'd3
    } pos_state_e;

    // Right-shifting Galois masks, each giving a maximal-length sequence.
    localparam logic [31:0] TAPS_W8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS_W16 = 32'h0000_B400;
    localparam logic [31:0] TAPS_W24 = 32'h00E1_0000;
    localparam logic [31:0] TAPS_W32 = 32'hA300_0000;

    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return TAPS_W8;
            24:      return TAPS_W24;
            32:      return TAPS_W32;
            default: return TAPS_W16;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running Galois LFSR with synchronous load; a zero load value is
// replaced by the seed so the register can never lock up at zero.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int          WIDTH = 16,
    parameter logic [31:0] SEED  = 32'h0000_ACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state
);

    localparam logic [31:0]      TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W    = SEED[WIDTH-1:0];

    logic [WIDTH-1:0] stepped;

    always_comb begin
        stepped = (state >> 1) ^ (state[0] ? TAPS : '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SEED_W;
        end else if (load) begin
            state <= (load_val == '0) ? SEED_W : load_val;
        end else begin
            state <= stepped;
        end
    end

endmodule

// File: rtl/lfsr_rand_pos.sv
// Random (x,y) generator: rejection-samples LFSR bits against X_MAX/Y_MAX,
// clamping after MAX_TRIES rejections, and holds the pair until accepted.
module lfsr_rand_pos
    import lfsr_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int          COORD_W   = 4,
    parameter int          X_MAX     = 15,
    parameter int          Y_MAX     = 15,
    parameter logic [31:0] SEED      = 32'h0000_ACE1,
    parameter int          MAX_TRIES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic               seed_load,
    input  logic [WIDTH-1:0]   seed_in,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [WIDTH-1:0]   lfsr_state
);

    localparam int                 TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0]   LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [31:0]        X_MAX_U  = 32'(X_MAX);
    localparam logic [31:0]        Y_MAX_U  = 32'(Y_MAX);
    localparam logic [COORD_W-1:0] X_CLAMP  = X_MAX_U[COORD_W-1:0];
    localparam logic [COORD_W-1:0] Y_CLAMP  = Y_MAX_U[COORD_W-1:0];

    pos_state_e         state;
    pos_state_e         state_nxt;
    logic [TRY_W-1:0]   tries;
    logic [COORD_W-1:0] cand_x;
    logic [COORD_W-1:0] cand_y;
    logic               x_ok;
    logic               y_ok;
    logic               give_up;

    lfsr_core #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (seed_load),
        .load_val (seed_in),
        .state    (lfsr_state)
    );

    // x draws from the low bits and y from the high bits of the same state.
    always_comb begin
        cand_x  = lfsr_state[COORD_W-1:0];
        cand_y  = lfsr_state[WIDTH-1 -: COORD_W];
        x_ok    = 32'(cand_x) <= X_MAX_U;
        y_ok    = 32'(cand_y) <= Y_MAX_U;
        give_up = (tries == LAST_TRY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (seed_load) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (req)              state_nxt = ST_GEN_X;
                ST_GEN_X: if (x_ok || give_up)  state_nxt = ST_GEN_Y;
                ST_GEN_Y: if (y_ok || give_up)  state_nxt = ST_DONE;
                ST_DONE:  if (out_ready)        state_nxt = ST_IDLE;
                default:                        state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // Clearing tries on every exit from a GEN state means each GEN state
    // is entered with a zero count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x     <= '0;
            y     <= '0;
            tries <= '0;
        end else if (seed_load) begin
            tries <= '0;
        end else begin
            case (state)
                ST_GEN_X: begin
                    if (x_ok) begin
                        x     <= cand_x;
                        tries <= '0;
                    end else if (give_up) begin
                        x     <= X_CLAMP;
                        tries <= '0;
                    end else begin
                        tries <= tries + 1'b1;
                    end
                end
                ST_GEN_Y: begin
                    if (y_ok) begin
                        y     <= cand_y;
                        tries <= '0;
                    end else if (give_up) begin
                        y     <= Y_CLAMP;
                        tries <= '0;
                    end else begin
                        tries <= tries + 1'b1;
                    end
                end
                default: tries <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rand_pos.sv
// Bench for lfsr_rand_pos: a default instance and a clamping instance,
// a reference LFSR model per instance, and queue-based output scoreboards.
module tb_lfsr_rand_pos;

    localparam logic [15:0] SEED16 = 16'hACE1;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // default instance
    logic        req, seed_load, out_ready, busy, out_valid;
    logic [15:0] seed_in, lfsr_state;
    logic [3:0]  x, y;

    // clamping instance
    logic        c_req, c_seed_load, c_out_ready, c_busy, c_out_valid;
    logic [15:0] c_seed_in, c_lfsr_state;
    logic [3:0]  c_x, c_y;

    lfsr_rand_pos #(
        .WIDTH(16), .COORD_W(4), .X_MAX(15), .Y_MAX(15),
        .SEED(32'h0000_ACE1), .MAX_TRIES(8)
    ) u_dut (
        .clk(clk), .reset(reset), .req(req), .seed_load(seed_load),
        .seed_in(seed_in), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .x(x), .y(y), .lfsr_state(lfsr_state)
    );

    lfsr_rand_pos #(
        .WIDTH(16), .COORD_W(4), .X_MAX(0), .Y_MAX(2),
        .SEED(32'h0000_ACE1), .MAX_TRIES(4)
    ) u_clamp (
        .clk(clk), .reset(reset), .req(c_req), .seed_load(c_seed_load),
        .seed_in(c_seed_in), .busy(c_busy), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .x(c_x), .y(c_y), .lfsr_state(c_lfsr_state)
    );

    // scoreboard state
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cexp_q[$];
    int         creq_q[$];
    int         clat_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] step16(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSRs, independent of the DUT.
    logic [15:0] model, c_model;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model   <= SEED16;
            c_model <= SEED16;
        end else begin
            model   <= seed_load ? ((seed_in == 16'h0) ? SEED16 : seed_in) : step16(model);
            c_model <= step16(c_model);
        end
    end

    // Behavioural prediction of one request, given the LFSR value just
    // before the edge that samples req.
    task automatic predict(input logic [15:0] m, input int xmax, input int ymax, input int mt,
                           output logic [3:0] px, output logic [3:0] py, output int lat);
        logic [15:0] s;
        int t;
        bit done;
        s = step16(m);
        lat = 0;
        t = 0;
        done = 0;
        while (!done) begin
            lat++;
            if (s[3:0] <= xmax) begin
                px = s[3:0]; done = 1;
            end else begin
                t++;
                if (t == mt) begin px = 4'(xmax); done = 1; end
            end
            s = step16(s);
        end
        t = 0;
        done = 0;
        while (!done) begin
            lat++;
            if (s[15:12] <= ymax) begin
                py = s[15:12]; done = 1;
            end else begin
                t++;
                if (t == mt) begin py = 4'(ymax); done = 1; end
            end
            s = step16(s);
        end
    endtask

    // monitor
    logic [7:0] mon_e;
    int         mon_rc, mon_el, mon_lat;
    always @(negedge clk) begin
        if (reset) begin
            check("lfsr_model", lfsr_state, model);
            check("clamp_lfsr_model", c_lfsr_state, c_model);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("x", x, mon_e[7:4]);
                    check("y", y, mon_e[3:0]);
                end
            end
            if (c_out_valid && c_out_ready) begin
                if (cexp_q.size() == 0) begin
                    check("clamp_unexpected_output", 1, 0);
                end else begin
                    mon_e   = cexp_q.pop_front();
                    mon_rc  = creq_q.pop_front();
                    mon_el  = clat_q.pop_front();
                    mon_lat = cyc - (mon_rc + 1);
                    check("clamp_x", c_x, mon_e[7:4]);
                    check("clamp_y", c_y, mon_e[3:0]);
                    check("clamp_x_zero", c_x, 0);
                    check("clamp_y_le2", c_y <= 4'd2, 1);
                    check("clamp_lat_le8", mon_lat <= 8, 1);
                    check("clamp_lat", mon_lat, mon_el);
                end
            end
        end
    end

    // driver tasks
    task automatic main_req(output logic [3:0] px, output logic [3:0] py);
        int lat;
        predict(model, 15, 15, 8, px, py, lat);
        exp_q.push_back({px, py});
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic clamp_req();
        logic [3:0] px, py;
        int lat;
        predict(c_model, 0, 2, 4, px, py, lat);
        cexp_q.push_back({px, py});
        creq_q.push_back(cyc);
        clat_q.push_back(lat);
        c_req = 1'b1;
        @(posedge clk); #1;
        c_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!c_busy) break;
            @(posedge clk); #1;
        end
        check("clamp_back_to_idle", c_busy, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] px, py;
        int zero_seen, early;

        reset = 1'b1;
        req = 0; seed_load = 0; seed_in = '0; out_ready = 1;
        c_req = 0; c_seed_load = 0; c_seed_in = '0; c_out_ready = 1;
        #1 reset = 1'b0;
        #1;
        check("rst_lfsr", lfsr_state, SEED16);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_clamp_lfsr", c_lfsr_state, SEED16);
        @(posedge clk); #1;
        check("rst_hold_lfsr", lfsr_state, SEED16);

        // First request right out of reset: states ACE1 -> E270 -> 7138.
        reset = 1'b1;
        exp_q.push_back({4'h0, 4'h7});
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        check("first_step", lfsr_state, 16'hE270);
        check("lat_e1_valid", out_valid, 0);
        check("lat_e1_busy", busy, 1);
        @(posedge clk); #1;
        check("second_step", lfsr_state, 16'h7138);
        check("lat_e2_valid_pre", out_valid, 0);
        @(posedge clk); #1;
        check("lat_e2_valid", out_valid, 1);
        check("third_step", lfsr_state, 16'h389C);
        @(posedge clk); #1;
        check("lat_idle_valid", out_valid, 0);
        check("lat_idle_busy", busy, 0);

        // Further minimum-latency requests with varying idle gaps.
        for (int i = 0; i < 6; i++) begin
            repeat (i) @(posedge clk);
            #1;
            main_req(px, py);
            @(posedge clk); #1;
            check("lat_mid_valid", out_valid, 0);
            @(posedge clk); #1;
            check("lat_valid", out_valid, 1);
            @(posedge clk); #1;
            check("lat_after_valid", out_valid, 0);
        end

        // Clamping instance.
        for (int i = 0; i < 50; i++) begin
            clamp_req();
        end

        // Backpressure with ignored req pulses.
        out_ready = 1'b0;
        main_req(px, py);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("bp_valid", out_valid, 1);
        for (int k = 0; k < 10; k++) begin
            req = (k % 2 == 0);
            @(posedge clk); #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_busy", busy, 1);
            check("bp_hold_x", x, px);
            check("bp_hold_y", y, py);
        end
        req = 1'b0;
        @(posedge clk); #1;
        check("bp_hold_valid_last", out_valid, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        check("bp_no_queued_req", busy, 0);

        // Seed load of zero while in GEN_X.
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        check("abort_in_gen", busy, 1);
        seed_load = 1'b1; seed_in = 16'h0000;
        @(posedge clk); #1;
        seed_load = 1'b0;
        check("seed0_lfsr", lfsr_state, SEED16);
        check("seed0_busy", busy, 0);
        check("seed0_valid", out_valid, 0);
        check("seed0_x_kept", x, px);
        check("seed0_y_kept", y, py);

        // Nonzero seed, then a request from the new state.
        seed_load = 1'b1; seed_in = 16'h1234;
        @(posedge clk); #1;
        seed_load = 1'b0;
        check("seed_lfsr", lfsr_state, 16'h1234);
        main_req(px, py);
        repeat (3) @(posedge clk);
        #1;
        check("seed_req_done", busy, 0);

        // Full period from ACE1.
        seed_load = 1'b1; seed_in = SEED16;
        @(posedge clk); #1;
        seed_load = 1'b0;
        check("period_start", lfsr_state, SEED16);
        zero_seen = 0;
        early = 0;
        for (int k = 1; k <= 65535; k++) begin
            @(posedge clk); #1;
            if (lfsr_state == 16'h0) zero_seen++;
            if (k < 65535 && lfsr_state == SEED16) early++;
        end
        check("period_end", lfsr_state, SEED16);
        check("period_zero", zero_seen, 0);
        check("period_early", early, 0);

        // Asynchronous reset while in GEN_Y.
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("rabort_busy_pre", busy, 1);
        check("rabort_valid_pre", out_valid, 0);
        #2 reset = 1'b0;
        #1;
        check("rabort_lfsr", lfsr_state, SEED16);
        check("rabort_x", x, 0);
        check("rabort_y", y, 0);
        check("rabort_valid", out_valid, 0);
        check("rabort_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        main_req(px, py);
        repeat (3) @(posedge clk);
        #1;
        check("recover_idle", busy, 0);

        check("exp_q_empty", exp_q.size(), 0);
        check("cexp_q_empty", cexp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
